cpu_io: RTL and testbench

CPU_IO -- requirements
Module: cpu_io

---
 rtl/cpu_io_pkg.sv | 36 +++
 rtl/io_debounce.sv | 52 +++++
 rtl/cpu_io.sv | 174 +++++++++++++++++
 tb/tb_cpu_io.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O block: port numbers, io_sel encodings,
// the NMI FSM state type and a port decode helper.
package cpu_io_pkg;

    // I/O port numbers (CRTC and PSG occupy an aligned pair each)
    localparam logic [7:0] PORT_FF   = 8'hFF;
    localparam logic [7:0] PORT_CRTC = 8'hFA;
    localparam logic [7:0] PORT_PSG  = 8'hF8;

    // io_sel encodings
    localparam logic [1:0] SEL_FF   = 2'd0;
    localparam logic [1:0] SEL_CRTC = 2'd1;
    localparam logic [1:0] SEL_PSG  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    // NMI FSM state type and encodings
    typedef logic [1:0] nmi_state_t;
    localparam nmi_state_t NMI_IDLE    = 2'd0;
    localparam nmi_state_t NMI_PULSE   = 2'd1;
    localparam nmi_state_t NMI_WAITREL = 2'd2;

    // Map a port number to its io_sel code; pairs decode on a[7:1].
    function automatic logic [1:0] decode_sel(input logic [7:0] port);
        logic [1:0] sel;
        sel = SEL_NONE;
        if (port == PORT_FF) begin
            sel = SEL_FF;
        end else if (port[7:1] == PORT_CRTC[7:1]) begin
            sel = SEL_CRTC;
        end else if (port[7:1] == PORT_PSG[7:1]) begin
            sel = SEL_PSG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a level debouncer.
// Ports:
//   clock    - system clock
//   reset    - synchronous active-high reset
//   btn_i    - asynchronous button input
//   level_o  - debounced level; changes only after DEBOUNCE_CYCLES
//              consecutive clocks at the new synchronised level
module io_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic level_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            // Any return to the current level restarts the count
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/cpu_io.sv
// CPU I/O port block: bus-cycle strobe generation, port decode, port 0xFF
// latch, read-data mux and a debounced NMI pulse generator.
// Ports:
//   clock, reset       - system clock, synchronous active-high reset
//   cep                - CPU clock enable; bus sampled only when high
//   iorq, rd, wr       - active-low CPU I/O request and strobes
//   a, d               - port number and write data
//   q                  - combinational read data
//   crtc_q, psg_q      - peripheral read data
//   cas_in             - cassette input, returned in bit 0 of port 0xFF
//   nmi_btn            - asynchronous NMI button, active-high
//   port_ff            - latched port 0xFF output
//   io_we, io_re       - one-clock write/read strobes
//   io_sel, io_a0      - decoded port and a[0], held between strobes
//   nmi                - active-low NMI to the CPU
module cpu_io
    import cpu_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned NMI_TICKS       = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cep,
    input  logic       iorq,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] q,
    input  logic [7:0] crtc_q,
    input  logic [7:0] psg_q,
    input  logic       cas_in,
    input  logic       nmi_btn,
    output logic [7:0] port_ff,
    output logic       io_we,
    output logic       io_re,
    output logic [1:0] io_sel,
    output logic       io_a0,
    output logic       nmi
);

    localparam int unsigned TickW = (NMI_TICKS > 1) ? $clog2(NMI_TICKS) : 1;

    // ---------------- I/O strobes ----------------
    logic       cyc_act, is_wr, fire;
    logic       armed_q, armed_d;
    logic       io_we_q, io_we_d, io_re_q, io_re_d;
    logic [1:0] sel_q, sel_d;
    logic       a0_q, a0_d;
    logic [7:0] port_ff_q, port_ff_d;

    assign cyc_act = ~iorq & (~wr | ~rd);
    // Write wins when both strobes are low
    assign is_wr   = ~iorq & ~wr;
    assign fire    = cep & cyc_act & armed_q;

    always_comb begin
        armed_d   = armed_q;
        // The arm is only set by a cep sample with the cycle inactive, so a
        // held cycle, or one in flight across reset, never strobes twice.
        if (cep) begin
            armed_d = ~cyc_act;
        end
        io_we_d   = fire & is_wr;
        io_re_d   = fire & ~is_wr;
        sel_d     = fire ? decode_sel(a) : sel_q;
        a0_d      = fire ? a[0] : a0_q;
        port_ff_d = (fire && is_wr && a == PORT_FF) ? d : port_ff_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            armed_q   <= 1'b0;
            io_we_q   <= 1'b0;
            io_re_q   <= 1'b0;
            sel_q     <= SEL_NONE;
            a0_q      <= 1'b0;
            port_ff_q <= 8'h00;
        end else begin
            armed_q   <= armed_d;
            io_we_q   <= io_we_d;
            io_re_q   <= io_re_d;
            sel_q     <= sel_d;
            a0_q      <= a0_d;
            port_ff_q <= port_ff_d;
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        q = 8'hFF;
        case (decode_sel(a))
            SEL_FF:   q = {port_ff_q[7:1], cas_in};
            SEL_CRTC: q = crtc_q;
            SEL_PSG:  q = psg_q;
            default:  q = 8'hFF;
        endcase
    end

    // ---------------- NMI ----------------
    logic             nmi_level;
    logic             level_prev_q;
    nmi_state_t       state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic             nmi_q, nmi_d;

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (nmi_btn),
        .level_o(nmi_level)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        nmi_d   = nmi_q;
        case (state_q)
            NMI_IDLE: begin
                if (nmi_level && !level_prev_q) begin
                    state_d = NMI_PULSE;
                    tick_d  = '0;
                    nmi_d   = 1'b0;
                end
            end
            NMI_PULSE: begin
                if (cep) begin
                    if (tick_q == TickW'(NMI_TICKS - 1)) begin
                        state_d = NMI_WAITREL;
                        tick_d  = '0;
                        nmi_d   = 1'b1;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
            end
            NMI_WAITREL: begin
                if (!nmi_level) begin
                    state_d = NMI_IDLE;
                end
            end
            default: begin
                state_d = NMI_IDLE;
                tick_d  = '0;
                nmi_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= NMI_IDLE;
            tick_q       <= '0;
            nmi_q        <= 1'b1;
            level_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            nmi_q        <= nmi_d;
            level_prev_q <= nmi_level;
        end
    end

    assign port_ff = port_ff_q;
    assign io_we   = io_we_q;
    assign io_re   = io_re_q;
    assign io_sel  = sel_q;
    assign io_a0   = a0_q;
    assign nmi     = nmi_q;

endmodule

// File: tb/tb_cpu_io.sv
// Directed bench for cpu_io with DEBOUNCE_CYCLES=4, NMI_TICKS=3 and cep
// high on every second clock.
module tb_cpu_io;

    logic       clock = 1'b0;
    logic       reset, cep, iorq, rd, wr, cas_in, nmi_btn;
    logic [7:0] a, d, crtc_q, psg_q;
    logic [7:0] q, port_ff;
    logic       io_we, io_re, io_a0, nmi;
    logic [1:0] io_sel;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    cpu_io #(
        .DEBOUNCE_CYCLES(4),
        .NMI_TICKS      (3)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .cep    (cep),
        .iorq   (iorq),
        .rd     (rd),
        .wr     (wr),
        .a      (a),
        .d      (d),
        .q      (q),
        .crtc_q (crtc_q),
        .psg_q  (psg_q),
        .cas_in (cas_in),
        .nmi_btn(nmi_btn),
        .port_ff(port_ff),
        .io_we  (io_we),
        .io_re  (io_re),
        .io_sel (io_sel),
        .io_a0  (io_a0),
        .nmi    (nmi)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change 1 time unit after the edge, cep alternates.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        cep = (cyc % 2 == 1);
    endtask

    task automatic run(input int n, output int we_n, output int re_n, output int lo_n);
        we_n = 0;
        re_n = 0;
        lo_n = 0;
        repeat (n) begin
            tick();
            if (io_we) we_n++;
            if (io_re) re_n++;
            if (!nmi)  lo_n++;
        end
    endtask

    task automatic bus_idle();
        iorq = 1'b1;
        rd   = 1'b1;
        wr   = 1'b1;
    endtask

    initial begin
        int we_n, re_n, lo_n, ticks;
        logic c;

        reset = 1'b1; cep = 1'b0; bus_idle();
        a = 8'h00; d = 8'h00; crtc_q = 8'h00; psg_q = 8'h00;
        cas_in = 1'b0; nmi_btn = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_port_ff", port_ff, 8'h00);
        check("rst_io_we",   io_we,   1'b0);
        check("rst_io_re",   io_re,   1'b0);
        check("rst_io_sel",  io_sel,  2'd3);
        check("rst_io_a0",   io_a0,   1'b0);
        check("rst_nmi",     nmi,     1'b1);
        run(4, we_n, re_n, lo_n);

        // Write to 0xFF held across several cep samples
        a = 8'hFF; d = 8'h5A; iorq = 1'b0; wr = 1'b0;
        run(8, we_n, re_n, lo_n);
        check("wr_ff_we_count", we_n, 1);
        check("wr_ff_re_count", re_n, 0);
        bus_idle();
        run(4, we_n, re_n, lo_n);
        check("wr_ff_sel",     io_sel,  2'd0);
        check("wr_ff_port_ff", port_ff, 8'h5A);
        cas_in = 1'b1;
        #1 check("rd_mux_ff_cas1", q, 8'h5B);
        cas_in = 1'b0;
        #1 check("rd_mux_ff_cas0", q, 8'h5A);

        // Read CRTC
        a = 8'hFA; crtc_q = 8'h3C; iorq = 1'b0; rd = 1'b0;
        #1 check("rd_crtc_q", q, 8'h3C);
        run(6, we_n, re_n, lo_n);
        check("rd_crtc_re_count", re_n, 1);
        check("rd_crtc_we_count", we_n, 0);
        bus_idle();
        run(4, we_n, re_n, lo_n);
        check("rd_crtc_sel", io_sel, 2'd1);
        check("rd_crtc_a0",  io_a0,  1'b0);

        // PSG data path on the combinational mux
        a = 8'hF8; psg_q = 8'hA7;
        #1 check("rd_psg_q", q, 8'hA7);

        // Read unmapped port
        a = 8'h10; iorq = 1'b0; rd = 1'b0;
        #1 check("rd_none_q", q, 8'hFF);
        run(6, we_n, re_n, lo_n);
        check("rd_none_re_count", re_n, 1);
        bus_idle();
        run(4, we_n, re_n, lo_n);
        check("rd_none_sel", io_sel, 2'd3);

        // rd and wr together: write only, PSG odd address
        a = 8'hF9; d = 8'h11; iorq = 1'b0; rd = 1'b0; wr = 1'b0;
        run(6, we_n, re_n, lo_n);
        check("both_we_count", we_n, 1);
        check("both_re_count", re_n, 0);
        bus_idle();
        run(4, we_n, re_n, lo_n);
        check("both_sel",     io_sel,  2'd2);
        check("both_a0",      io_a0,   1'b1);
        check("both_port_ff", port_ff, 8'h5A);

        // Interrupt acknowledge: no strobe, decode held
        a = 8'hFF; iorq = 1'b0;
        run(6, we_n, re_n, lo_n);
        check("inta_we_count", we_n, 0);
        check("inta_re_count", re_n, 0);
        check("inta_sel_hold", io_sel, 2'd2);
        bus_idle();
        run(4, we_n, re_n, lo_n);

        // Clean NMI press: nmi falls on the 7th clock after the press
        nmi_btn = 1'b1;
        run(6, we_n, re_n, lo_n);
        check("nmi_pre", nmi, 1'b1);
        tick();
        check("nmi_start", nmi, 1'b0);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            c = cep;
            tick();
            if (c) ticks++;
            if (nmi) break;
        end
        check("nmi_end",       nmi,   1'b1);
        check("nmi_cep_ticks", ticks, 3);

        // Held button: no second pulse
        run(40, we_n, re_n, lo_n);
        check("nmi_held_no_pulse", lo_n, 0);
        nmi_btn = 1'b0;
        run(12, we_n, re_n, lo_n);

        // Bounce 1,0,1 shorter than the debounce window
        nmi_btn = 1'b1; tick();
        nmi_btn = 1'b0; tick();
        nmi_btn = 1'b1; tick();
        nmi_btn = 1'b0;
        run(20, we_n, re_n, lo_n);
        check("nmi_bounce_no_pulse", lo_n, 0);

        // Reset mid-pulse
        nmi_btn = 1'b1;
        run(7, we_n, re_n, lo_n);
        check("nmi_rst_start", nmi, 1'b0);
        tick();
        reset = 1'b1; nmi_btn = 1'b0;
        tick();
        check("rst_mid_nmi",     nmi,     1'b1);
        check("rst_mid_port_ff", port_ff, 8'h00);
        check("rst_mid_sel",     io_sel,  2'd3);

        // Write cycle in flight across reset is suppressed
        a = 8'hFF; d = 8'h77; iorq = 1'b0; wr = 1'b0;
        tick();
        reset = 1'b0;
        run(6, we_n, re_n, lo_n);
        check("rst_io_we_suppressed", we_n, 0);
        check("rst_io_port_ff",       port_ff, 8'h00);
        bus_idle();
        run(4, we_n, re_n, lo_n);

        // Fresh write after the bus went idle
        a = 8'hFF; d = 8'hC3; iorq = 1'b0; wr = 1'b0;
        run(6, we_n, re_n, lo_n);
        check("post_rst_we_count", we_n, 1);
        check("post_rst_port_ff",  port_ff, 8'hC3);
        bus_idle();
        run(2, we_n, re_n, lo_n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
